// File: rtl/vga_sync_monitor_if.sv
// VGA pixel-bus bundle: pixel strobe, sync pins and 4:4:4 colour, as seen on the connector.
interface vga_sync_monitor_if;
  logic       pix_en;
  logic       vga_hs;
  logic       vga_vs;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;

  modport master (output pix_en, vga_hs, vga_vs, vga_r, vga_g, vga_b);
  modport slave  (input  pix_en, vga_hs, vga_vs, vga_r, vga_g, vga_b);
endinterface

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: measures line/frame geometry, tracks lock,
// counts locked frames and captures the colour at a programmable probe pixel.
module vga_sync_monitor #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned V_ACTIVE    = 480,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic               clk,
  input  logic               rst,
  vga_sync_monitor_if.slave  vga,
  input  logic [9:0]         probe_x,
  input  logic [9:0]         probe_y,
  output logic               locked,
  output logic               h_err,
  output logic               v_err,
  output logic [15:0]        frame_cnt,
  output logic [11:0]        line_len,
  output logic [11:0]        probe_rgb,
  output logic               probe_valid
);

  localparam logic [11:0] H_TOT  = 12'(H_TOTAL);
  localparam logic [11:0] TO_LIM = 12'(2 * H_TOTAL);
  localparam logic [11:0] HS_W   = 12'(H_SYNC);
  localparam logic [11:0] AX_OFF = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_TOT  = 12'(V_TOTAL);
  localparam logic [11:0] VS_W   = 12'(V_SYNC);
  localparam logic [11:0] AY_OFF = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {ST_SEARCH, ST_TRACK, ST_LOCKED} state_e;

  state_e      state_q, state_d;
  logic [7:0]  clean_q, clean_d;
  logic        dirty_q, dirty_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_line_q, vs_line_d;
  logic        h_seen_q, h_seen_d;
  logic        hs_wv_q, hs_wv_d;
  logic        vs_wv_q, vs_wv_d;
  logic        armed_q, armed_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic [11:0] hs_w_q, hs_w_d;
  logic [11:0] vs_w_q, vs_w_d;
  logic [9:0]  px_q, px_d;
  logic [9:0]  py_q, py_d;
  logic [11:0] line_len_q, line_len_d;
  logic [11:0] probe_rgb_q, probe_rgb_d;
  logic        probe_valid_q, probe_valid_d;
  logic        h_err_q, h_err_d;
  logic        v_err_q, v_err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic        hs_act, vs_act;
  logic        fs, h_det, v_det, tmo, err;
  logic [11:0] ax, ay;

  assign hs_act = (vga.vga_hs == SYNC_POL);
  assign vs_act = (vga.vga_vs == SYNC_POL);

  // Datapath: counters, width checks, probe capture; all gated by the pixel strobe.
  always_comb begin
    hs_prev_d     = hs_prev_q;
    vs_line_d     = vs_line_q;
    h_seen_d      = h_seen_q;
    hs_wv_d       = hs_wv_q;
    vs_wv_d       = vs_wv_q;
    armed_d       = armed_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hs_w_d        = hs_w_q;
    vs_w_d        = vs_w_q;
    px_d          = px_q;
    py_d          = py_q;
    line_len_d    = line_len_q;
    probe_rgb_d   = probe_rgb_q;
    probe_valid_d = 1'b0;
    fs            = 1'b0;
    h_det         = 1'b0;
    v_det         = 1'b0;
    tmo           = 1'b0;
    ax            = '0;
    ay            = '0;
    if (vga.pix_en) begin
      hs_prev_d = hs_act;
      if (hs_act && !hs_prev_q) begin
        h_cnt_d  = '0;
        h_seen_d = 1'b1;
        hs_w_d   = 12'd1;
        hs_wv_d  = 1'b1;
        // The very first line after reset/power-up has unknown start, so it is not length-checked.
        if (h_seen_q) begin
          line_len_d = h_cnt_q + 12'd1;
          if (h_cnt_q + 12'd1 != H_TOT) h_det = 1'b1;
        end
        vs_line_d = vs_act;
        if (vs_act && !vs_line_q) begin
          fs      = 1'b1;
          if (state_q != ST_SEARCH && v_cnt_q + 12'd1 != V_TOT) v_det = 1'b1;
          v_cnt_d = '0;
          vs_w_d  = 12'd1;
          vs_wv_d = 1'b1;
          px_d    = probe_x;
          py_d    = probe_y;
          armed_d = 1'b1;
        end else begin
          if (v_cnt_q != '1) v_cnt_d = v_cnt_q + 12'd1;
          if (vs_act) begin
            if (vs_w_q != '1) vs_w_d = vs_w_q + 12'd1;
          end else if (vs_line_q && vs_wv_q) begin
            if (vs_w_q != VS_W) v_det = 1'b1;
            vs_wv_d = 1'b0;
          end
        end
      end else begin
        if (h_cnt_q < TO_LIM) begin
          h_cnt_d = h_cnt_q + 12'd1;
          if (h_cnt_q + 12'd1 == TO_LIM) tmo = 1'b1;
        end
        if (hs_act) begin
          if (hs_w_q != '1) hs_w_d = hs_w_q + 12'd1;
        end else if (hs_prev_q && hs_wv_q) begin
          if (hs_w_q != HS_W) h_det = 1'b1;
          hs_wv_d = 1'b0;
        end
      end
      ax = h_cnt_d - AX_OFF;
      ay = v_cnt_d - AY_OFF;
      if (armed_d && ax < H_ACT && ay < V_ACT &&
          ax == {2'b00, px_d} && ay == {2'b00, py_d}) begin
        probe_rgb_d   = {vga.vga_r, vga.vga_g, vga.vga_b};
        probe_valid_d = 1'b1;
      end
    end
  end

  assign err     = h_det | v_det | tmo;
  assign h_err_d = h_err_q | h_det | tmo;
  assign v_err_d = v_err_q | v_det;

  // Lock FSM: an error on the frame-start sample itself marks the closing frame dirty.
  always_comb begin
    state_d     = state_q;
    clean_d     = clean_q;
    dirty_d     = dirty_q | err;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      ST_SEARCH: begin
        if (fs) begin
          state_d = ST_TRACK;
          clean_d = '0;
          dirty_d = 1'b0;
        end
      end
      ST_TRACK: begin
        if (tmo) begin
          state_d = ST_SEARCH;
        end else if (fs) begin
          dirty_d = 1'b0;
          if (!dirty_q && !err) begin
            clean_d = clean_q + 8'd1;
            if (clean_q + 8'd1 >= LOCK_N) begin
              state_d     = ST_LOCKED;
              frame_cnt_d = frame_cnt_q + 16'd1;
            end
          end else begin
            clean_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (err) begin
          state_d = ST_SEARCH;
        end else if (fs) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Sync history resets to "asserted" so an edge is only seen after a real deasserted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SEARCH;
      clean_q       <= '0;
      dirty_q       <= 1'b0;
      hs_prev_q     <= 1'b1;
      vs_line_q     <= 1'b1;
      h_seen_q      <= 1'b0;
      hs_wv_q       <= 1'b0;
      vs_wv_q       <= 1'b0;
      armed_q       <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hs_w_q        <= '0;
      vs_w_q        <= '0;
      px_q          <= '0;
      py_q          <= '0;
      line_len_q    <= '0;
      probe_rgb_q   <= '0;
      probe_valid_q <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      clean_q       <= clean_d;
      dirty_q       <= dirty_d;
      hs_prev_q     <= hs_prev_d;
      vs_line_q     <= vs_line_d;
      h_seen_q      <= h_seen_d;
      hs_wv_q       <= hs_wv_d;
      vs_wv_q       <= vs_wv_d;
      armed_q       <= armed_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_w_q        <= hs_w_d;
      vs_w_q        <= vs_w_d;
      px_q          <= px_d;
      py_q          <= py_d;
      line_len_q    <= line_len_d;
      probe_rgb_q   <= probe_rgb_d;
      probe_valid_q <= probe_valid_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign locked      = (state_q == ST_LOCKED);
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign line_len    = line_len_q;
  assign probe_rgb   = probe_rgb_q;
  assign probe_valid = probe_valid_q;

endmodule
